edge_event_arbiter: RTL and testbench

Multi-channel edge-event collector and round-robin scheduler for the IO library. Each of N level inputs gets its own edge detector. Detected edges are latched as pending events, and pending events are delivered one at a time over a valid/ready interface. A single consumer (UART logger, LED sequencer, interrupt register) can therefore service many buttons or switches without losing or double-counting edges.

---
 rtl/edge_event_arbiter_if.sv | 9 +
 rtl/edge_event_arbiter.sv | 82 ++++++++
 tb/tb_edge_event_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/edge_event_arbiter_if.sv
// edge_event_arbiter_if: event delivery bus (valid/id/rise from the arbiter, ready from the consumer)
interface edge_event_arbiter_if #(parameter int IDW = 2) ();
  logic           event_valid;
  logic [IDW-1:0] event_id;
  logic           event_rise;
  logic           event_ready;
  modport master (output event_valid, event_id, event_rise, input event_ready);
  modport slave (input event_valid, event_id, event_rise, output event_ready);
endinterface

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-channel edge detect, pending latch and round-robin delivery of one event at a time
// Ports: clk, reset (async, active high), level[N] synchronous inputs, ev (master: event_valid/event_id/
// event_rise out, event_ready in), pending[N], overflow[N] sticky, overflow_clr pulse.
// Define EDGE_ARB_FALLING_EN to also report falling edges; otherwise only rising edges produce events.
module edge_event_arbiter #(
  parameter int N = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          level,
  edge_event_arbiter_if.master  ev,
  output logic [N-1:0]          pending,
  output logic [N-1:0]          overflow,
  input  logic                  overflow_clr
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t state, state_d;
  logic [N-1:0] prev, rise_tick, tick, clr_mask;
  logic [IDW-1:0] rr_ptr, sel;
  logic found, take;
  int idx;
  assign rise_tick = level & ~prev;
`ifdef EDGE_ARB_FALLING_EN
  logic [N-1:0] edge_type;
  assign tick = rise_tick | (~level & prev);
`else
  assign tick = rise_tick;
`endif
  // first pending channel at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    sel = '0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr) + k;
      idx = idx >= N ? idx - N : idx;
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel = IDW'(idx);
      end
    end
  end
  assign take = (state == IDLE) && |pending;
  assign clr_mask = take ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_d;
  always_comb state_d = state == IDLE ? (|pending ? PRESENT : IDLE) : (ev.event_ready ? IDLE : PRESENT);
  always_comb begin
    ev.event_valid = state == PRESENT;
`ifndef EDGE_ARB_FALLING_EN
    ev.event_rise = state == PRESENT;
`endif
  end
  // a new tick beats the clear from selection, and only counts as overflow when the bit stays pending
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= '0;
      pending <= '0;
      overflow <= '0;
      rr_ptr <= '0;
      ev.event_id <= '0;
`ifdef EDGE_ARB_FALLING_EN
      edge_type <= '0;
      ev.event_rise <= 1'b0;
`endif
    end else begin
      prev <= level;
      pending <= (pending & ~clr_mask) | tick;
      overflow <= (overflow & ~{N{overflow_clr}}) | (tick & pending & ~clr_mask);
`ifdef EDGE_ARB_FALLING_EN
      edge_type <= (edge_type & ~tick) | rise_tick;
      if (take) ev.event_rise <= edge_type[sel];
`endif
      if (take) begin
        ev.event_id <= sel;
        rr_ptr <= sel == IDW'(N - 1) ? '0 : sel + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed test-plan scenarios plus random stimulus against a behavioural model
module tb_edge_event_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] level = '0;
  logic [N-1:0] pending, overflow;
  logic overflow_clr = 1'b0;
  int vectors = 0;
  int errors = 0;
  edge_event_arbiter_if #(.IDW(2)) ev ();
  edge_event_arbiter #(.N(N)) dut (
    .clk(clk), .reset(reset), .level(level), .ev(ev.master),
    .pending(pending), .overflow(overflow), .overflow_clr(overflow_clr)
  );
  always #5 clk = ~clk;
  bit mprev[N], mpend[N], mtype[N], movf[N];
  int mrr, mid;
  bit mvalid, mrise;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] pack(bit a[N]);
    logic [31:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = a[i];
    return r;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mprev[i] = 0; mpend[i] = 0; mtype[i] = 0; movf[i] = 0;
    end
    mrr = 0; mid = 0; mvalid = 0; mrise = 0;
  endtask
  task automatic model_step(logic [N-1:0] l, bit rdy, bit oc);
    bit r[N], t[N];
    bit tk = 0;
    int s = 0;
    for (int i = 0; i < N; i++) begin
      r[i] = l[i] && !mprev[i];
      t[i] = r[i];
`ifdef EDGE_ARB_FALLING_EN
      t[i] = r[i] || (!l[i] && mprev[i]);
`endif
    end
    if (!mvalid)
      for (int k = 0; k < N; k++)
        if (!tk && mpend[(mrr + k) % N]) begin
          tk = 1;
          s = (mrr + k) % N;
        end
    if (tk) begin
      mvalid = 1; mid = s; mrise = mtype[s]; mrr = (s + 1) % N;
    end else if (mvalid && rdy) mvalid = 0;
    for (int i = 0; i < N; i++) begin
      bit cl = tk && (i == s);
      movf[i] = (t[i] && mpend[i] && !cl) || (movf[i] && !oc);
      mpend[i] = t[i] || (mpend[i] && !cl);
      if (t[i]) mtype[i] = r[i];
      mprev[i] = l[i];
    end
  endtask
  task automatic compare();
    chk("valid", ev.event_valid, mvalid);
    chk("pending", pending, pack(mpend));
    chk("overflow", overflow, pack(movf));
    if (mvalid) begin
      chk("id", ev.event_id, mid);
      chk("rise", ev.event_rise, mrise);
    end
  endtask
  task automatic cyc(logic [N-1:0] l, bit rdy, bit oc);
    level = l; ev.event_ready = rdy; overflow_clr = oc;
    model_step(l, rdy, oc);
    @(negedge clk);
    compare();
  endtask
  task automatic do_reset(logic [N-1:0] l);
    reset = 1'b1; level = l; ev.event_ready = 1'b0; overflow_clr = 1'b0;
    #1;
    chk("rst_valid", ev.event_valid, 0);
    chk("rst_id", ev.event_id, 0);
    chk("rst_rise", ev.event_rise, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overflow", overflow, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    int e;
    logic [N-1:0] l;
    ev.event_ready = 1'b0;
    do_reset('0);
    cyc(4'b0000, 0, 0);
    cyc(4'b0000, 0, 0);
    cyc(4'b0100, 0, 0);
    chk("s1_pending", pending, 4'b0100);
    cyc(4'b0100, 1, 0);
    chk("s1_valid", ev.event_valid, 1);
    chk("s1_id", ev.event_id, 2);
    chk("s1_rise", ev.event_rise, 1);
    cyc(4'b0100, 1, 0);
    chk("s1_drop", ev.event_valid, 0);
    chk("s1_empty", pending, 0);
    do_reset('0);
    cyc(4'b0000, 1, 0);
    cyc(4'b1111, 1, 0);
    e = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(4'b1111, 1, 0);
      if (ev.event_valid) begin
        chk("s2_order", ev.event_id, e);
        e++;
      end
    end
    chk("s2_count", e, 4);
    chk("s2_no_ovf", overflow, 0);
    do_reset('0);
    cyc(4'b0001, 0, 0);
    cyc(4'b0001, 0, 0);
    cyc(4'b0011, 0, 0);
    cyc(4'b0001, 0, 0);
    cyc(4'b0011, 0, 0);
    chk("s3_overflow", overflow, 4'b0010);
    e = 0;
    for (int c = 0; c < 4; c++) begin
      cyc(4'b0011, 1, 0);
      if (ev.event_valid) begin
        chk("s3_id", ev.event_id, 1);
        e++;
      end
    end
    chk("s3_single", e, 1);
    cyc(4'b0011, 0, 1);
    chk("s3_clr", overflow, 0);
    do_reset('0);
    cyc(4'b0010, 0, 0);
    cyc(4'b0000, 0, 0);
    cyc(4'b0011, 0, 0);
    cyc(4'b0011, 1, 0);
    cyc(4'b0011, 1, 0);
    chk("s4_wrap0", ev.event_id, 0);
    cyc(4'b0011, 1, 0);
    cyc(4'b0011, 1, 0);
    chk("s4_wrap1", ev.event_id, 1);
    do_reset('0);
    cyc(4'b1000, 1, 0);
    for (int c = 0; c < 3; c++) cyc(4'b1000, 1, 0);
    cyc(4'b0000, 1, 0);
`ifdef EDGE_ARB_FALLING_EN
    chk("s5_pending", pending, 4'b1000);
    cyc(4'b0000, 1, 0);
    chk("s5_valid", ev.event_valid, 1);
    chk("s5_id", ev.event_id, 3);
    chk("s5_rise", ev.event_rise, 0);
`else
    chk("s5_pending", pending, 0);
    cyc(4'b0000, 1, 0);
    chk("s5_valid", ev.event_valid, 0);
`endif
    do_reset('0);
    cyc(4'b0001, 0, 0);
    cyc(4'b0001, 0, 0);
    cyc(4'b1011, 0, 0);
    chk("s6_pre_valid", ev.event_valid, 1);
    chk("s6_pre_pending", pending, 4'b1010);
    do_reset('0);
    for (int c = 0; c < 3; c++) begin
      cyc(4'b0000, 0, 0);
      chk("s6_quiet", ev.event_valid, 0);
    end
    do_reset('0);
    cyc(4'b0001, 0, 0);
    cyc(4'b0001, 0, 0);
    chk("s6_valid", ev.event_valid, 1);
    chk("s6_id", ev.event_id, 0);
    chk("s6_rise", ev.event_rise, 1);
    l = '0;
    for (int c = 0; c < 3000; c++) begin
      l = l ^ N'($urandom & $urandom);
      if ($urandom_range(0, 299) == 0) do_reset(l);
      cyc(l, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
